// File: rtl/masked_rnd_source_if.sv
// Seeding handshake and randomness output bus of masked_rnd_source.
// master drives seeding/enable, slave is the generator block.
interface masked_rnd_source_if #(
  parameter int NRND = 8
);
  logic            seed_start;
  logic            seed_valid;
  logic            seed_ready;
  logic [31:0]     seed_data;
  logic            en;
  logic [NRND-1:0] rnd;
  logic            rnd_valid;
  logic            busy;

  modport master (
    output seed_start, seed_valid, seed_data, en,
    input  seed_ready, rnd, rnd_valid, busy
  );

  modport slave (
    input  seed_start, seed_valid, seed_data, en,
    output seed_ready, rnd, rnd_valid, busy
  );
endinterface

// File: rtl/masked_rnd_source.sv
// Bank of xorshift64 generators feeding the rnd inputs of masked gadgets.
// Software-seeded word by word, then warmed up before delivering NRND bits per enabled cycle.
//
// state      | meaning
// S_UNSEEDED | after reset, outputs idle until seed_start
// S_SEED     | accepting NWORDS 32-bit seed words
// S_WARMUP   | discarding WARMUP generator steps
// S_RUN      | rnd valid, generators step when en=1
module masked_rnd_source #(
  parameter int NRND   = 8,
  parameter int WARMUP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  masked_rnd_source_if.slave  bus
);
  localparam int NINST  = (NRND + 63) / 64;
  localparam int NWORDS = 2 * NINST;
  localparam int NB     = 64 * NINST;
  localparam int CW     = $clog2(NWORDS);
  localparam int WW     = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

  typedef enum logic [1:0] {S_UNSEEDED, S_SEED, S_WARMUP, S_RUN} state_t;

  state_t          state;
  logic [NB-1:0]   inst;
  logic [NB-1:0]   inst_step;
  logic [NB-1:0]   inst_load;
  logic [CW-1:0]   word_cnt;
  logic [WW-1:0]   warm_cnt;
  logic            last_word;
  logic            xfer;
  logic [NRND-1:0] rnd_q;
  logic            rnd_valid_q;
  logic            busy_q;

  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  assign bus.seed_ready = (state == S_SEED) && !bus.seed_start;
  assign xfer           = bus.seed_valid && bus.seed_ready;
  assign last_word      = (word_cnt == CW'(NWORDS - 1));
  assign bus.rnd        = rnd_q;
  assign bus.rnd_valid  = rnd_valid_q;
  assign bus.busy       = busy_q;

  // Word k lands at flat offset 32*k: even words fill the low half, odd the high half.
  always_comb begin
    inst_step = '0;
    inst_load = inst;
    for (int i = 0; i < NINST; i++) begin
      inst_step[64*i +: 64] = xs_step(inst[64*i +: 64]);
    end
    inst_load[32*int'(word_cnt) +: 32] = bus.seed_data;
    if (last_word) begin
      for (int i = 0; i < NINST; i++) begin
        if (inst_load[64*i +: 64] == 64'd0) begin
          inst_load[64*i +: 64] = GOLDEN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_UNSEEDED;
      inst        <= '0;
      word_cnt    <= '0;
      warm_cnt    <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.seed_start) begin
      state       <= S_SEED;
      word_cnt    <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state)
        S_UNSEEDED: ;
        S_SEED: begin
          if (xfer) begin
            inst     <= inst_load;
            word_cnt <= word_cnt + CW'(1);
            if (last_word) begin
              if (WARMUP == 0) begin
                state       <= S_RUN;
                rnd_q       <= inst_load[NRND-1:0];
                rnd_valid_q <= 1'b1;
                busy_q      <= 1'b0;
              end else begin
                state    <= S_WARMUP;
                warm_cnt <= WW'(WARMUP);
              end
            end
          end
        end
        S_WARMUP: begin
          inst     <= inst_step;
          warm_cnt <= warm_cnt - WW'(1);
          if (warm_cnt == WW'(1)) begin
            state       <= S_RUN;
            rnd_q       <= inst_step[NRND-1:0];
            rnd_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.en) begin
            inst  <= inst_step;
            rnd_q <= inst_step[NRND-1:0];
          end
        end
        default: state <= S_UNSEEDED;
      endcase
    end
  end
endmodule

// File: tb/tb_masked_rnd_source.sv
// Directed and randomized checks of masked_rnd_source against an xorshift64 reference model.
module tb_masked_rnd_source;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_rnd_source_if #(.NRND(8))   ia ();
  masked_rnd_source_if #(.NRND(8))   ib ();
  masked_rnd_source_if #(.NRND(100)) ic ();

  masked_rnd_source #(.NRND(8),   .WARMUP(0))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  masked_rnd_source #(.NRND(8),   .WARMUP(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  masked_rnd_source #(.NRND(100), .WARMUP(3))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  int checks = 0;
  int errors = 0;
  logic [63:0]  ma;
  logic [63:0]  mb;
  logic [63:0]  mc [2];
  logic [31:0]  cw [4];
  logic [127:0] mask100;

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [63:0] fix(input logic [63:0] x);
    return (x == 64'd0) ? 64'h9E3779B97F4A7C15 : x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_c();
    logic [127:0] cat;
    cat = {mc[1], mc[0]};
    return cat & mask100;
  endfunction

  // Seeds dut_c with cw[] (seed_valid toggling randomly), then follows warm-up and RUN.
  task automatic load_and_run_c(input int ncyc);
    int k;
    int cyc;
    logic v;
    k = 0;
    cyc = 0;
    ic.en = 1'b1;
    while (k < 4 && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      ic.seed_valid = v;
      ic.seed_data  = v ? cw[k] : 32'($urandom());
      #1;
      chk("c_seed_ready", ic.seed_ready, 1);
      tick();
      if (v) k++;
      cyc++;
    end
    chk("c_seed_words_accepted", k, 4);
    ic.seed_valid = 1'b0;
    mc[0] = fix({cw[1], cw[0]});
    mc[1] = fix({cw[3], cw[2]});
    for (int i = 0; i < 3; i++) begin
      chk("c_warm_busy", ic.busy, 1);
      chk("c_warm_valid", ic.rnd_valid, 0);
      tick();
      mc[0] = xs(mc[0]);
      mc[1] = xs(mc[1]);
    end
    for (int i = 0; i < ncyc; i++) begin
      chk("c_valid", ic.rnd_valid, 1);
      chk("c_rnd", ic.rnd, exp_c());
      tick();
      mc[0] = xs(mc[0]);
      mc[1] = xs(mc[1]);
    end
  endtask

  initial begin
    mask100 = (128'd1 << 100) - 128'd1;
    ia.seed_start = 0; ia.seed_valid = 0; ia.seed_data = 0; ia.en = 0;
    ib.seed_start = 0; ib.seed_valid = 0; ib.seed_data = 0; ib.en = 0;
    ic.seed_start = 0; ic.seed_valid = 0; ic.seed_data = 0; ic.en = 0;

    #2;
    chk("rst_a_rnd", ia.rnd, 0);
    chk("rst_a_valid", ia.rnd_valid, 0);
    chk("rst_a_busy", ia.busy, 0);
    chk("rst_a_ready", ia.seed_ready, 0);
    chk("rst_c_rnd", ic.rnd, 0);
    #10 rst_n = 1'b1;
    tick();

    // dut_a, no warm-up: seed 1 then 0
    ia.seed_valid = 1; ia.en = 1;
    #1;
    chk("a_unseeded_ready", ia.seed_ready, 0);
    tick();
    chk("a_unseeded_valid", ia.rnd_valid, 0);
    ia.seed_valid = 0; ia.en = 0;
    ia.seed_start = 1;
    tick();
    ia.seed_start = 0;
    #1;
    chk("a_seed_busy", ia.busy, 1);
    chk("a_seed_ready", ia.seed_ready, 1);
    ia.seed_valid = 1; ia.seed_data = 32'h1;
    tick();
    ia.seed_data = 32'h0;
    tick();
    ia.seed_valid = 0; ia.en = 1;
    ma = 64'h1;
    chk("a_first_valid", ia.rnd_valid, 1);
    chk("a_first_rnd", ia.rnd, 8'h01);
    chk("a_first_busy", ia.busy, 0);
    tick();
    ma = xs(ma);
    chk("a_step1_model", ma, 64'h40822041);
    chk("a_step1_rnd", ia.rnd, 8'h41);
    tick();
    ma = xs(ma);
    chk("a_step2_rnd", ia.rnd, ma[7:0]);

    // mid-RUN reseed with seed_valid held high
    ia.en = 0; ia.seed_start = 1; ia.seed_valid = 1; ia.seed_data = 32'hDEAD_BEEF;
    #1;
    chk("a_restart_ready", ia.seed_ready, 0);
    tick();
    chk("a_restart_valid", ia.rnd_valid, 0);
    chk("a_restart_rnd", ia.rnd, 0);
    chk("a_restart_busy", ia.busy, 1);
    ia.seed_start = 0; ia.seed_data = 32'h1;
    tick();
    ia.seed_data = 32'h0;
    tick();
    ia.seed_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("a_hold_rnd", ia.rnd, 8'h01);
      chk("a_hold_valid", ia.rnd_valid, 1);
      tick();
    end
    ia.en = 1;
    tick();
    chk("a_resume_rnd", ia.rnd, 8'h41);
    ia.en = 0;

    // dut_b, zero seed with 16-step warm-up, en held high throughout
    ib.en = 1; ib.seed_start = 1;
    tick();
    ib.seed_start = 0; ib.seed_valid = 1; ib.seed_data = 0;
    tick();
    tick();
    ib.seed_valid = 0;
    mb = 64'h9E3779B97F4A7C15;
    for (int i = 0; i < 16; i++) begin
      chk("b_warm_busy", ib.busy, 1);
      chk("b_warm_valid", ib.rnd_valid, 0);
      chk("b_warm_rnd", ib.rnd, 0);
      tick();
      mb = xs(mb);
    end
    chk("b_run_valid", ib.rnd_valid, 1);
    chk("b_run_busy", ib.busy, 0);
    chk("b_run_rnd", ib.rnd, mb[7:0]);
    tick();
    mb = xs(mb);
    chk("b_run_rnd_next", ib.rnd, mb[7:0]);
    ib.en = 0;

    // dut_c, NRND=100 across two instances
    ic.seed_start = 1;
    tick();
    ic.seed_start = 0;
    for (int i = 0; i < 4; i++) cw[i] = 32'($urandom());
    load_and_run_c(50);

    ic.seed_start = 1; ic.seed_valid = 1; ic.seed_data = 32'h1234_5678;
    #1;
    chk("c_restart_ready", ic.seed_ready, 0);
    tick();
    ic.seed_start = 0;
    chk("c_restart_valid", ic.rnd_valid, 0);
    chk("c_restart_rnd", ic.rnd, 0);
    chk("c_restart_busy", ic.busy, 1);
    for (int i = 0; i < 4; i++) cw[i] = 32'($urandom()) ^ 32'hA5A5_0000;
    load_and_run_c(20);

    // asynchronous reset in the middle of dut_b warm-up
    ib.seed_start = 1;
    tick();
    ib.seed_start = 0; ib.seed_valid = 1; ib.seed_data = 32'($urandom());
    tick();
    ib.seed_data = 32'($urandom());
    tick();
    ib.seed_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("r_pre_busy", ib.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("r_busy", ib.busy, 0);
    chk("r_valid", ib.rnd_valid, 0);
    chk("r_rnd", ib.rnd, 0);
    chk("r_ready", ib.seed_ready, 0);
    chk("r_c_valid", ic.rnd_valid, 0);
    #3 rst_n = 1'b1;
    ib.seed_valid = 1;
    tick();
    tick();
    tick();
    chk("r_after_busy", ib.busy, 0);
    chk("r_after_valid", ib.rnd_valid, 0);
    chk("r_after_ready", ib.seed_ready, 0);
    ib.seed_valid = 0; ib.seed_start = 1;
    tick();
    ib.seed_start = 0;
    #1;
    chk("r_restart_busy", ib.busy, 1);
    chk("r_restart_ready", ib.seed_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/masked_rnd_source.md
Name: masked_rnd_source

Overview:
- Produces the fresh randomness bus consumed by masked gadgets (refresh and AND gadgets), which take their random input on the rnd port.
- Bank of xorshift64 generators, software-seeded through a valid/ready word interface.
- After a configurable warm-up, delivers NRND new random bits every enabled cycle, with a validity flag.
- Sits between the top-level seeding logic and the rnd inputs of the masked datapath.

Parameters:
- NRND, default 8: width of the random output bus, in bits; any value ≥1.
- WARMUP, default 16: number of generator steps discarded after seeding; ≥0.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- rst_n  input  1  asynchronous, active-low reset.
- seed_start  input  1  single-cycle pulse; starts or restarts the seeding sequence.
- seed_valid  input  1  seed word present on seed_data.
- seed_ready  output  1  block accepts a seed word this cycle.
- seed_data  input  32  seed word.
- en  input  1  advances the generators while in RUN.
- rnd  output  NRND  random bits, registered.
- rnd_valid  output  1  rnd is fresh output of a seeded generator.
- busy  output  1  high during SEED and WARMUP.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Sizing: NINST = ceil(NRND/64) xorshift64 instances; NWORDS = 2*NINST seed words.
- Step function per instance, 64-bit, shifts zero-filled, applied in this order:
  - x ^= x<<13
  - x ^= x>>7
  - x ^= x<<17
- rnd = bits [NRND-1:0] of {inst[NINST-1],...,inst[0]} while state==RUN; otherwise forced to 0.
- Reset (rst_n=0, immediate): state=UNSEEDED, all instance states 0, word counter 0, warm-up counter 0, rnd=0, rnd_valid=0, seed_ready=0, busy=0.
- UNSEEDED:
  - Outputs idle; en ignored.
  - seed_start=1 -> SEED next cycle, word counter cleared.
- SEED:
  - seed_ready = !seed_start (combinational).
  - Transfer occurs when seed_valid & seed_ready.
  - Word k (k = 0..NWORDS-1) is written to inst[k/2] bits [31:0] if k is even, bits [63:32] if odd.
  - On the transfer of word NWORDS-1, any instance whose final value is all-zero is loaded with 64'h9E3779B97F4A7C15 instead.
  - Same edge: go to WARMUP with the counter set to WARMUP, or straight to RUN if WARMUP=0.
- WARMUP:
  - Every cycle all instances step and the counter decrements.
  - When the counter reaches 1 and steps: -> RUN.
  - Exactly WARMUP steps occur; en is ignored.
- RUN:
  - rnd_valid=1.
  - en=1: all instances step each edge, giving new rnd the next cycle.
  - en=0: state and rnd hold.
- seed_start in SEED, WARMUP or RUN:
  - Next cycle state=SEED, word counter 0; rnd_valid=0 and rnd=0 from that cycle.
  - Instance states are not cleared but are fully overwritten by the new seed words.
  - In the start cycle seed_ready=0, so no word is lost or double-counted.
- seed_valid outside SEED is ignored. seed_start in UNSEEDED, or in the same cycle as the final word, takes priority; that final word is not accepted.
- rnd_valid and rnd change only on clock edges; all registers are reset asynchronously.
- Latency:
  - Final seed word accepted at edge E -> rnd_valid=1 after edge E+WARMUP.
  - While in RUN with en=1 -> one new rnd per cycle.

Test Plan:
- NRND=8, WARMUP=0; seed_start; words 0x00000001, 0x00000000; en=1 -> first cycle rnd_valid=1, rnd=0x01; next cycle rnd=0x41 (state 0x40822041); following cycle rnd matches the reference model.
- Same seed, en held 0 for 5 cycles in RUN -> rnd stays 0x01, rnd_valid stays 1; en=1 -> 0x41.
- NRND=8, WARMUP=16; words 0, 0 -> zero fix-up applied; rnd_valid rises exactly 16 cycles after the final transfer; rnd equals the 16-step model of 0x9E3779B97F4A7C15; busy high throughout.
- NRND=100 (NINST=2); four words with seed_valid toggling randomly -> all words land in the correct instance and half; the 100-bit rnd sequence matches the model for 50 cycles.
- Mid-RUN seed_start while seed_valid=1 -> seed_ready=0 that cycle; next cycle rnd_valid=0, rnd=0, busy=1; reseed with different words -> the new sequence matches the model.
- Assert rst_n during WARMUP, between clock edges -> rnd_valid, rnd, busy and seed_ready go to 0 immediately; after release, state is UNSEEDED and seed_start is required to proceed.
